fir_mac_sequencer: RTL and testbench

Serial, resource-shared FIR controller: it sequences one signed multiplier and one accumulator across all taps of a real-coefficient FIR instead of instantiating one multiplier per tap. It accepts samples through a valid/ready handshake and keeps the sample history in a circular buffer. Coefficients are held in a runtime-writable bank. Each output is truncated and saturated the same way as the team's parallel transposed FIR. It is used where the sample rate is at most clk/(NumTaps+2) and multipliers are scarce.

---
 rtl/fir_mac_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: serial FIR that reuses one signed multiplier and one
// accumulator across every tap. Samples arrive on a valid/ready handshake and
// go into a circular history buffer. Each MAC pass takes NumTaps cycles. The
// result is truncated and saturated to InputLengthBits.
//
// Ports
//   clk             clock
//   rst             synchronous active-high reset
//   in_valid        sample offered
//   in_ready        sample accepted when high (IDLE only)
//   in              signed input sample
//   coeff_wr_en     coefficient write strobe
//   coeff_wr_addr   tap index to write
//   coeff_wr_data   signed coefficient value
//   coeff_wr_ready  coefficient write accepted when high (IDLE only)
//   out_valid       one-cycle pulse per result
//   out             signed filtered sample, held between pulses
module fir_mac_sequencer #(
   parameter int unsigned InputLengthBits       = 8,
   parameter int unsigned CoefficientLengthBits = 10,
   parameter int unsigned AccumulatorLengthBits = 20,
   parameter int unsigned NumTaps               = 3,
   parameter int unsigned OutputTruncationBits  = 10,
   parameter int          Coefficients [NumTaps] = '{-300, 511, 300},
   localparam int unsigned AddrW = (NumTaps > 1) ? $clog2(NumTaps) : 1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic signed [InputLengthBits-1:0]       in,
   input  logic                                    coeff_wr_en,
   input  logic        [AddrW-1:0]                 coeff_wr_addr,
   input  logic signed [CoefficientLengthBits-1:0] coeff_wr_data,
   output logic                                    coeff_wr_ready,
   output logic                                    out_valid,
   output logic signed [InputLengthBits-1:0]       out
);

   localparam int unsigned InW   = InputLengthBits;
   localparam int unsigned CoefW = CoefficientLengthBits;
   localparam int unsigned AccW  = AccumulatorLengthBits;
   localparam int unsigned ProdW = InputLengthBits + CoefficientLengthBits;
   localparam int unsigned TopBitsToDrop =
      AccumulatorLengthBits - InputLengthBits - OutputTruncationBits;
   localparam logic [AddrW-1:0] LastTap = AddrW'(NumTaps - 1);
   localparam logic signed [InW-1:0] OutMax = {1'b0, {(InW-1){1'b1}}};
   localparam logic signed [InW-1:0] OutMin = {1'b1, {(InW-1){1'b0}}};

   // Reject configurations that cannot work.
   if (NumTaps < 1) begin : g_err_taps
      $error("fir_mac_sequencer: NumTaps must be at least 1");
   end
   if (AccumulatorLengthBits < InputLengthBits + OutputTruncationBits) begin : g_err_acc
      $error("fir_mac_sequencer: accumulator narrower than input plus truncation bits");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MAC,
      ST_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic signed [AccW-1:0]  acc_q, acc_d;
   logic [AddrW-1:0]        k_q, k_d;
   logic [AddrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic signed [InW-1:0]   hist_q [NumTaps];
   logic signed [InW-1:0]   hist_d [NumTaps];
   logic signed [CoefW-1:0] coeff_q [NumTaps];
   logic signed [CoefW-1:0] coeff_d [NumTaps];
   logic signed [InW-1:0]   out_q, out_d;
   logic                    out_valid_q, out_valid_d;
   logic                    ready_q, ready_d;

   logic [AddrW-1:0]        rd_idx_c;
   logic signed [ProdW-1:0] prod_c;
   logic [TopBitsToDrop:0]  top_c;
   logic signed [InW-1:0]   sat_c;
   logic                    coeff_addr_ok_c;

   // History index for tap k: (wr_ptr - k) mod NumTaps, k never exceeds NumTaps-1.
   always_comb begin
      if (wr_ptr_q >= k_q) begin
         rd_idx_c = wr_ptr_q - k_q;
      end else begin
         rd_idx_c = AddrW'(NumTaps) + wr_ptr_q - k_q;
      end
   end

   // Full-precision signed product of the selected sample and coefficient.
   assign prod_c = ProdW'(hist_q[rd_idx_c]) * ProdW'(coeff_q[k_q]);

   // Truncate toward -inf, saturate when the dropped top bits are not a sign extension.
   assign top_c = acc_q[AccW-1 -: TopBitsToDrop+1];
   always_comb begin
      if ((&top_c) || !(|top_c)) begin
         sat_c = acc_q[AccW-1-TopBitsToDrop : OutputTruncationBits];
      end else if (acc_q[AccW-1]) begin
         sat_c = OutMin;
      end else begin
         sat_c = OutMax;
      end
   end

   assign coeff_addr_ok_c = (32'(coeff_wr_addr) < NumTaps);

   // Next-state and datapath control.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      k_d         = k_q;
      wr_ptr_d    = wr_ptr_q;
      hist_d      = hist_q;
      coeff_d     = coeff_q;
      out_d       = out_q;
      out_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (coeff_wr_en && coeff_addr_ok_c) begin
               coeff_d[coeff_wr_addr] = coeff_wr_data;
            end
            if (in_valid) begin
               hist_d[wr_ptr_q] = in;
               acc_d            = '0;
               k_d              = '0;
               state_d          = ST_MAC;
            end
         end
         ST_MAC: begin
            acc_d = acc_q + AccW'(prod_c);
            if (k_q == LastTap) begin
               state_d = ST_DONE;
            end else begin
               k_d = k_q + AddrW'(1);
            end
         end
         ST_DONE: begin
            out_d       = sat_c;
            out_valid_d = 1'b1;
            wr_ptr_d    = (wr_ptr_q == LastTap) ? '0 : wr_ptr_q + AddrW'(1);
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ready_d = (state_d == ST_IDLE);
   end

   // State and datapath registers; reset also restores history and coefficients.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         k_q         <= '0;
         wr_ptr_q    <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         ready_q     <= 1'b1;
         for (int i = 0; i < int'(NumTaps); i++) begin
            hist_q[i]  <= '0;
            coeff_q[i] <= CoefW'(Coefficients[i]);
         end
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         k_q         <= k_d;
         wr_ptr_q    <= wr_ptr_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         ready_q     <= ready_d;
         hist_q      <= hist_d;
         coeff_q     <= coeff_d;
      end
   end

   assign in_ready       = ready_q;
   assign coeff_wr_ready = ready_q;
   assign out_valid      = out_valid_q;
   assign out            = out_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed testbench for fir_mac_sequencer with default parameters.
module tb_fir_mac_sequencer;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] din;
   logic              coeff_wr_en;
   logic [1:0]        coeff_wr_addr;
   logic signed [9:0] coeff_wr_data;
   logic              coeff_wr_ready;
   logic              out_valid;
   logic signed [7:0] dout;

   int errors = 0;
   int checks = 0;

   fir_mac_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in             (din),
      .coeff_wr_en    (coeff_wr_en),
      .coeff_wr_addr  (coeff_wr_addr),
      .coeff_wr_data  (coeff_wr_data),
      .coeff_wr_ready (coeff_wr_ready),
      .out_valid      (out_valid),
      .out            (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic write_coeff(input logic [1:0] a, input logic signed [9:0] d);
      coeff_wr_en   = 1'b1;
      coeff_wr_addr = a;
      coeff_wr_data = d;
      @(posedge clk); #1;
      coeff_wr_en = 1'b0;
   endtask

   // Offer one sample and wait (bounded) for its result. Optional coefficient
   // write either in the accept cycle or in the first MAC cycle.
   task automatic send_sample(input logic signed [7:0] s, input bit wr_acc, input bit wr_mac,
                              input logic [1:0] waddr, input logic signed [9:0] wdata,
                              output logic signed [7:0] o, output int lat, output int low);
      in_valid = 1'b1;
      din      = s;
      if (wr_acc) begin
         coeff_wr_en = 1'b1; coeff_wr_addr = waddr; coeff_wr_data = wdata;
      end
      @(posedge clk); #1;
      in_valid    = 1'b0;
      coeff_wr_en = 1'b0;
      lat = 0; low = 0; o = '0;
      if (!in_ready) low++;
      if (wr_mac) begin
         coeff_wr_en = 1'b1; coeff_wr_addr = waddr; coeff_wr_data = wdata;
      end
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         coeff_wr_en = 1'b0;
         lat++;
         if (!in_ready) low++;
         if (out_valid) begin
            o = dout;
            break;
         end
      end
   endtask

   task automatic test_reset();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
      checks++; if (coeff_wr_ready !== 1'b1) begin errors++; $display("FAIL reset coeff_wr_ready got %b exp 1", coeff_wr_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
      checks++; if (dout !== 8'sd0) begin errors++; $display("FAIL reset out got %0d exp 0", dout); end
   endtask

   task automatic test_impulse();
      logic signed [7:0] ins [4] = '{8'sd100, 8'sd0, 8'sd0, 8'sd0};
      logic signed [7:0] exp [4] = '{-8'sd30, 8'sd49, 8'sd29, 8'sd0};
      logic signed [7:0] o;
      int lat, low;
      for (int i = 0; i < 4; i++) begin
         send_sample(ins[i], 1'b0, 1'b0, 2'd0, 10'sd0, o, lat, low);
         checks++; if (o !== exp[i]) begin errors++; $display("FAIL impulse[%0d] out got %0d exp %0d", i, o, exp[i]); end
         checks++; if (lat !== 4) begin errors++; $display("FAIL impulse[%0d] latency got %0d exp 4", i, lat); end
         checks++; if (low !== 4) begin errors++; $display("FAIL impulse[%0d] in_ready low cycles got %0d exp 4", i, low); end
         if (i == 0) begin
            repeat (3) @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL impulse pulse width out_valid got %b exp 0", out_valid); end
            checks++; if (dout !== -8'sd30) begin errors++; $display("FAIL impulse hold out got %0d exp -30", dout); end
         end
      end
   endtask

   task automatic test_coeff_race();
      logic signed [7:0] o;
      int lat, low;
      logic signed [7:0] expa [3] = '{-8'sd30, 8'sd49, 8'sd29};
      logic signed [7:0] expb [3] = '{-8'sd30, 8'sd0, 8'sd29};
      do_reset();
      // write of coeff[1]=0 during MAC must be dropped
      in_valid = 1'b1; din = 8'sd100;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (coeff_wr_ready !== 1'b0) begin errors++; $display("FAIL race coeff_wr_ready in MAC got %b exp 0", coeff_wr_ready); end
      coeff_wr_en = 1'b1; coeff_wr_addr = 2'd1; coeff_wr_data = 10'sd0;
      @(posedge clk); #1;
      coeff_wr_en = 1'b0;
      o = '0;
      for (int c = 0; c < 20; c++) begin
         if (out_valid) begin o = dout; break; end
         @(posedge clk); #1;
      end
      checks++; if (o !== expa[0]) begin errors++; $display("FAIL race_mac[0] out got %0d exp %0d", o, expa[0]); end
      for (int i = 1; i < 3; i++) begin
         send_sample(8'sd0, 1'b0, 1'b0, 2'd0, 10'sd0, o, lat, low);
         checks++; if (o !== expa[i]) begin errors++; $display("FAIL race_mac[%0d] out got %0d exp %0d", i, o, expa[i]); end
      end
      // write of coeff[1]=0 together with the accept applies to that pass
      for (int i = 0; i < 3; i++) begin
         send_sample((i == 0) ? 8'sd100 : 8'sd0, (i == 0), 1'b0, 2'd1, 10'sd0, o, lat, low);
         checks++; if (o !== expb[i]) begin errors++; $display("FAIL race_idle[%0d] out got %0d exp %0d", i, o, expb[i]); end
      end
      // out-of-range address is ignored
      write_coeff(2'd3, 10'sd0);
      for (int i = 0; i < 3; i++) begin
         send_sample((i == 0) ? 8'sd100 : 8'sd0, 1'b0, 1'b0, 2'd0, 10'sd0, o, lat, low);
         checks++; if (o !== expb[i]) begin errors++; $display("FAIL race_addr3[%0d] out got %0d exp %0d", i, o, expb[i]); end
      end
   endtask

   task automatic test_reset_mid_mac();
      logic signed [7:0] o;
      int lat, low;
      bit seen;
      logic signed [7:0] exp [3] = '{-8'sd30, 8'sd49, 8'sd29};
      in_valid = 1'b1; din = 8'sd100;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst in_ready got %b exp 1", in_ready); end
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst out_valid seen got %b exp 0", seen); end
      checks++; if (dout !== 8'sd0) begin errors++; $display("FAIL midrst out got %0d exp 0", dout); end
      for (int i = 0; i < 3; i++) begin
         send_sample((i == 0) ? 8'sd100 : 8'sd0, 1'b0, 1'b0, 2'd0, 10'sd0, o, lat, low);
         checks++; if (o !== exp[i]) begin errors++; $display("FAIL midrst_impulse[%0d] out got %0d exp %0d", i, o, exp[i]); end
      end
   endtask

   task automatic test_neg_trunc();
      logic signed [7:0] o;
      int lat, low;
      do_reset();
      write_coeff(2'd1, 10'sd0);
      write_coeff(2'd2, 10'sd0);
      send_sample(-8'sd1, 1'b0, 1'b0, 2'd0, 10'sd0, o, lat, low);
      checks++; if (o !== 8'sd0) begin errors++; $display("FAIL trunc_neg1 out got %0d exp 0", o); end
      send_sample(8'sd1, 1'b0, 1'b0, 2'd0, 10'sd0, o, lat, low);
      checks++; if (o !== -8'sd1) begin errors++; $display("FAIL trunc_pos1 out got %0d exp -1", o); end
   endtask

   task automatic test_saturation();
      logic signed [7:0] o;
      int lat, low;
      logic signed [7:0] expp [4] = '{8'sd63, 8'sd126, 8'sd127, 8'sd127};
      logic signed [7:0] expn [4] = '{8'sd62, -8'sd65, -8'sd128, -8'sd128};
      do_reset();
      for (int t = 0; t < 3; t++) write_coeff(2'(t), 10'sd511);
      for (int i = 0; i < 4; i++) begin
         send_sample(8'sd127, 1'b0, 1'b0, 2'd0, 10'sd0, o, lat, low);
         checks++; if (o !== expp[i]) begin errors++; $display("FAIL sat_pos[%0d] out got %0d exp %0d", i, o, expp[i]); end
      end
      for (int i = 0; i < 4; i++) begin
         send_sample(-8'sd128, 1'b0, 1'b0, 2'd0, 10'sd0, o, lat, low);
         checks++; if (o !== expn[i]) begin errors++; $display("FAIL sat_neg[%0d] out got %0d exp %0d", i, o, expn[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int samples [20] = '{127, -128, 127, -128, 100, 50, -50, 0, 1, -1,
                           127, 127, 127, -128, -128, -128, 3, 77, -90, 0};
      int coef [3] = '{-300, 511, 300};
      int expv [20];
      int idx, nout, prev_acc, acc, v;
      do_reset();
      // reference: y[n] = clamp(floor(sum c[k]*x[n-k] / 1024))
      for (int n = 0; n < 20; n++) begin
         acc = 0;
         for (int k = 0; k < 3; k++) if (n - k >= 0) acc += coef[k] * samples[n-k];
         v = acc >>> 10;
         if (v > 127) v = 127;
         if (v < -128) v = -128;
         expv[n] = v;
      end
      idx = 0; nout = 0; prev_acc = -1;
      for (int cyc = 0; cyc < 300 && nout < 20; cyc++) begin
         in_valid = (idx < 20);
         if (in_ready && idx < 20) begin
            din = 8'(samples[idx]);
            if (idx > 0) begin
               checks++; if (cyc - prev_acc !== 5) begin errors++; $display("FAIL b2b spacing[%0d] got %0d exp 5", idx, cyc - prev_acc); end
            end
            prev_acc = cyc;
            idx++;
         end
         @(posedge clk); #1;
         if (out_valid) begin
            checks++; if (dout !== 8'(expv[nout])) begin errors++; $display("FAIL b2b out[%0d] got %0d exp %0d", nout, dout, expv[nout]); end
            nout++;
         end
      end
      in_valid = 1'b0;
      checks++; if (nout !== 20) begin errors++; $display("FAIL b2b output count got %0d exp 20", nout); end
      checks++; if (idx !== 20) begin errors++; $display("FAIL b2b accept count got %0d exp 20", idx); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; din = '0;
      coeff_wr_en = 1'b0; coeff_wr_addr = '0; coeff_wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_impulse();
      test_coeff_race();
      test_reset_mid_mac();
      test_neg_trunc();
      test_saturation();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
